// File: rtl/rom_if.sv
// Access bus for the writable ROM: write enable, shared address, write data and registered read data.
// Signal names follow the processor-side names (WE, Address, D, Q).
interface rom_if #(
  parameter int unsigned n = 8
);
  localparam int unsigned AW = 5;

  logic          WE;
  logic [AW-1:0] Address;
  logic [n-1:0]  D;
  logic [n-1:0]  Q;

  modport master (
    output WE,
    output Address,
    output D,
    input  Q
  );

  modport slave (
    input  WE,
    input  Address,
    input  D,
    output Q
  );
endinterface

// File: rtl/rom.sv
// 32 x n writable "ROM": registered read (read-first on same-address write), run-time write port,
// and an asynchronous initialize that restores a fixed image (word a = 8'hA0 + a) and clears Q.
module rom #(
  parameter int unsigned n = 8
) (
  input  logic  clk,
  input  logic  initialize,
  rom_if.slave  bus
);
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned BASE  = 32'hA0;

  logic [n-1:0] r_mem [DEPTH];
  logic [n-1:0] r_q;

  // Default image word: low byte of BASE + a, then resized to n bits (zero-extend or truncate).
  function automatic logic [n-1:0] image_word(input int unsigned a);
    logic [7:0] w_byte;
    w_byte = 8'(BASE + a);
    return n'(w_byte);
  endfunction

  // Storage and read register share one process so the write is discarded while initialize is high
  // and the read naturally returns the pre-write word.
  always_ff @(posedge clk or posedge initialize) begin
    if (initialize) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        r_mem[AW'(a)] <= image_word(a);
      end
      r_q <= '0;
    end else begin
      r_q <= r_mem[bus.Address];
      if (bus.WE) begin
        r_mem[bus.Address] <= bus.D;
      end
    end
  end

  assign bus.Q = r_q;

endmodule

// File: tb/tb_rom.sv
// Scoreboard bench for rom: expected read data is queued when an access is driven and
// compared one clock edge later; asynchronous initialize behaviour is checked directly.
module tb_rom;
  logic clk = 1'b0;
  logic initialize = 1'b0;

  always #5 clk = ~clk;

  rom_if #(.n(8)) bus ();

  rom #(.n(8)) dut (
    .clk        (clk),
    .initialize (initialize),
    .bus        (bus)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  model[32];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) model[a] = 8'(32'hA0 + a);
  endtask

  // One access: drive on the falling edge, queue the expected (read-first) word, check after the rise.
  task automatic cycle(input logic we, input logic [4:0] addr, input logic [7:0] d, input string tag);
    logic [7:0] e;
    @(negedge clk);
    bus.WE      = we;
    bus.Address = addr;
    bus.D       = d;
    exp_q.push_back(model[addr]);
    if (we) model[addr] = d;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 8'h01, 8'h00);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.Q, e);
    end
  endtask

  initial begin
    bus.WE      = 1'b0;
    bus.Address = '0;
    bus.D       = '0;
    for (int a = 0; a < 32; a++) model[a] = 'x;

    // Initialize asserted between edges: Q clears without a clock edge.
    @(posedge clk);
    #2;
    initialize = 1'b1;
    model_reset();
    #1;
    check("init_async_q", bus.Q, 8'h00);
    @(negedge clk);
    initialize = 1'b0;
    cycle(1'b0, 5'd0, 8'hxx, "rd_a0_after_init");

    // Sweep with D undriven (X) and WE low.
    for (int a = 0; a < 16; a++) cycle(1'b0, 5'(a), 8'hxx, "sweep");
    cycle(1'b0, 5'd31, 8'hxx, "rd_a31");
    cycle(1'b0, 5'd8,  8'hxx, "rd_a8");

    // Single write then readback, neighbour untouched.
    cycle(1'b1, 5'd5, 8'h3C, "wr_a5_q");
    cycle(1'b0, 5'd5, 8'hxx, "rd_a5_written");
    cycle(1'b0, 5'd4, 8'hxx, "rd_a4_neighbour");

    // Read-during-write returns the old word, new word on the next edge.
    cycle(1'b1, 5'd7, 8'h55, "rdw_a7_old");
    cycle(1'b0, 5'd7, 8'hxx, "rdw_a7_new");

    // Mid-cycle initialize restores the image over the earlier write.
    @(posedge clk);
    #3;
    initialize = 1'b1;
    model_reset();
    #1;
    check("init_mid_q", bus.Q, 8'h00);
    @(negedge clk);
    initialize = 1'b0;
    cycle(1'b0, 5'd5, 8'hxx, "rd_a5_restored");

    // Write attempt held across two edges while initialize is high must be discarded.
    @(negedge clk);
    initialize  = 1'b1;
    bus.WE      = 1'b1;
    bus.Address = 5'd9;
    bus.D       = 8'hFF;
    model_reset();
    #1;
    check("init_hold_async_q", bus.Q, 8'h00);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("init_hold_q", bus.Q, 8'h00);
    end
    @(negedge clk);
    initialize = 1'b0;
    bus.WE     = 1'b0;
    cycle(1'b0, 5'd9, 8'hxx, "rd_a9_no_write");

    // Random mixed traffic against the model.
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), "random");
    end

    // Final sweep of every word to catch any stray corruption.
    for (int a = 0; a < 32; a++) cycle(1'b0, 5'(a), 8'hxx, "final_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
